// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   - uart_tx_state_e : transmit FSM state encoding (3 bits)
//   - UART_DATA_W     : data bits per frame
//   - UART_IDLE_LEVEL : line level while no frame is in progress
package uart_pkg;

    localparam int unsigned UART_DATA_W  = 8;
    localparam int unsigned UART_STATE_W = 3;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [UART_STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// uart_tx_sync_fifo: single-clock FIFO built from a register array.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_en_i/wr_data_i push request and byte; dropped while full
//   rd_en_i          pop request; ignored while empty
//   rd_data_o        head entry (valid while empty_o=0), no write bypass
//   clr_overflow_i   clears the sticky overflow flag
//   full_o/empty_o/level_o/overflow_o  registered status
module uart_tx_sync_fifo #(
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              clr_overflow_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [FIFO_AW:0]  level_o,
    output logic              overflow_o
);

    localparam int unsigned PTR_W = FIFO_AW + 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              push_ok, pop_ok;

    // Status is evaluated on registered flags, so a push into a full FIFO
    // is rejected even when a pop happens in the same cycle.
    always_comb begin
        push_ok    = wr_en_i && !full_q;
        pop_ok     = rd_en_i && !empty_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_ok);
        // Extra pointer MSB makes the difference span 0..DEPTH.
        level_d    = wr_ptr_d - rd_ptr_d;
        full_d     = (level_d == PTR_W'(DEPTH));
        empty_d    = (level_d == '0);
        overflow_d = overflow_q;
        if (clr_overflow_i) overflow_d = 1'b0;
        if (wr_en_i && full_q) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered UART transmitter. Bytes pushed into a FIFO are
// serialized on txd, LSB first, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, wr_data      push request and byte
//   clr_overflow        clears the sticky overflow flag
//   full, empty, level  FIFO status
//   overflow            sticky: a push arrived while full
//   busy                frame in progress
//   tx_done             one-cycle pulse during the last clock of each stop bit
//   txd                 registered serial line, idles high
// Build option: `define UART_TX_PARITY_EN adds an even parity bit.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_SET_COUNTER = 10516,
    parameter int unsigned FIFO_AW          = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   clr_overflow,
    output logic                   full,
    output logic                   empty,
    output logic [FIFO_AW:0]       level,
    output logic                   overflow,
    output logic                   busy,
    output logic                   tx_done,
    output logic                   txd
);

    localparam int unsigned CNT_W = (BAUD_SET_COUNTER > 2) ? $clog2(BAUD_SET_COUNTER) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_SET_COUNTER - 1);
    // tx_done is registered, so it is armed one clock before the stop bit ends.
    localparam logic [CNT_W-1:0] DONE_ARM = CNT_W'(BAUD_SET_COUNTER - 2);
    localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_W - 1);

    uart_tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] sh_q, sh_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif
    logic                   pop_c, load_c, bit_end_c;
    logic [UART_DATA_W-1:0] fifo_rd_data;

    uart_tx_sync_fifo #(
        .FIFO_AW (FIFO_AW),
        .DATA_W  (UART_DATA_W)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .rd_en_i        (pop_c),
        .rd_data_o      (fifo_rd_data),
        .clr_overflow_i (clr_overflow),
        .full_o         (full),
        .empty_o        (empty),
        .level_o        (level),
        .overflow_o     (overflow)
    );

    // Next-state: bit timing, shifting and frame sequencing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        pop_c     = 1'b0;
        load_c    = 1'b0;
        bit_end_c = (cnt_q == BIT_LAST);

        if (state_q != IDLE) cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (!empty) load_c = 1'b1;
            end
            START: begin
                if (bit_end_c) begin
                    txd_d   = sh_q[0];
                    sh_d    = {1'b0, sh_q[UART_DATA_W-1:1]};
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = par_q;
                        state_d = PARITY;
`else
                        txd_d   = UART_IDLE_LEVEL;
                        state_d = STOP;
`endif
                    end else begin
                        txd_d = sh_q[0];
                        sh_d  = {1'b0, sh_q[UART_DATA_W-1:1]};
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_c) begin
                    txd_d   = UART_IDLE_LEVEL;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == DONE_ARM) done_d = 1'b1;
                if (bit_end_c) begin
                    if (!empty) begin
                        load_c = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                txd_d   = UART_IDLE_LEVEL;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Frame start shared by IDLE and back-to-back STOP.
        if (load_c) begin
            pop_c   = 1'b1;
            sh_d    = fifo_rd_data;
            txd_d   = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_rd_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            txd_q   <= UART_IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered (BAUD_SET_COUNTER=4, FIFO_AW=2). Stimulus pushes
// expected bytes into a queue; a line monitor decodes frames and checks them.
module tb_uart_tx_buffered;

    localparam int unsigned BAUD = 4;
    localparam int unsigned AW   = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS    = 11;
    localparam int EXP_DONE = 22;
`else
    localparam int NBITS    = 10;
    localparam int EXP_DONE = 21;
`endif
    localparam int FRAME_CLK = NBITS * BAUD;

    logic          clk, rst_n, wr_en, clr_overflow;
    logic [7:0]    wr_data;
    logic          full, empty, overflow, busy, tx_done, txd;
    logic [AW:0]   level;

    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;
    int            done_cnt = 0;
    int            frames = 0;
    logic [7:0]    exp_q[$];
    int            done_cyc[$];

    uart_tx_buffered #(.BAUD_SET_COUNTER(BAUD), .FIFO_AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .busy         (busy),
        .tx_done      (tx_done),
        .txd          (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit expect_frame);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_frame) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0 || empty !== 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(n < 2000), 32'd1);
    endtask

    // Line monitor: decodes each frame and checks bit stability, start/stop,
    // parity and tx_done placement; aborts quietly on reset.
    initial begin : monitor
        logic [7:0] byt;
        logic [7:0] expb;
        logic       bitv, shape_ok, aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txd === 1'b0) begin
                shape_ok = 1'b1;
                aborted  = 1'b0;
                byt      = '0;
                bitv     = 1'b0;
                for (int b = 0; b < NBITS && !aborted; b++) begin
                    for (int c = 0; c < int'(BAUD) && !aborted; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                        end else begin
                            if (c == 0) bitv = txd;
                            else if (txd !== bitv) shape_ok = 1'b0;
                            if (tx_done !== ((b == NBITS-1) && (c == int'(BAUD)-1))) shape_ok = 1'b0;
                        end
                    end
                    if (!aborted) begin
                        if (b >= 1 && b <= 8) byt[b-1] = bitv;
                        else if (b == NBITS-1 && bitv !== 1'b1) shape_ok = 1'b0;
                        else if (b == 9 && NBITS == 11 && bitv !== ^byt) shape_ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    frames++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'(byt), 32'hFFFF_FFFF);
                    end else begin
                        expb = exp_q.pop_front();
                        check("frame_byte", 32'(byt), 32'(expb));
                    end
                    check("frame_shape", 32'(shape_ok), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n, c0;
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        #2 rst_n = 1'b1;

        // Single byte 0x55: latency, frame length, tx_done timing.
        done_cyc.delete();
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
        @(negedge clk);
        wr_en = 1'b0; c0 = cyc;
        check("s_txd_c0", 32'(txd), 32'd1);
        check("s_level_c0", 32'(level), 32'd1);
        check("s_empty_c0", 32'(empty), 32'd0);
        @(negedge clk);
        check("s_txd_c1", 32'(txd), 32'd0);
        check("s_busy_c1", 32'(busy), 32'd1);
        check("s_level_c1", 32'(level), 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("s_busy_cycles", 32'(n), 32'(FRAME_CLK));
        check("s_done_count", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) check("s_done_cycle", 32'(done_cyc[0] - c0), 32'(FRAME_CLK));
        wait_idle("single");

        // Back-to-back: no gap between frames.
        done_cyc.delete();
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge clk);
        wr_data = 8'h3C; exp_q.push_back(8'h3C);
        check("b_level_after_first", 32'(level), 32'd1);
        @(negedge clk);
        wr_en = 1'b0;
        check("b_level_push_pop", 32'(level), 32'd1);
        wait_idle("b2b");
        check("b_done_count", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2) check("b_done_gap", 32'(done_cyc[1] - done_cyc[0]), 32'(FRAME_CLK));

        // Full / overflow: six pushes, sixth dropped.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                check("o_level_full", 32'(level), 32'd4);
                check("o_full", 32'(full), 32'd1);
                check("o_ovf_before", 32'(overflow), 32'd0);
            end
            wr_en = 1'b1;
            wr_data = 8'(8'h11 * (i + 1));
            if (i < 5) exp_q.push_back(8'(8'h11 * (i + 1)));
        end
        @(negedge clk);
        check("o_ovf_set", 32'(overflow), 32'd1);
        check("o_level_hold", 32'(level), 32'd4);
        wr_data = 8'h77; clr_overflow = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; clr_overflow = 1'b0;
        check("o_set_wins", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("o_ovf_clr", 32'(overflow), 32'd0);
        wait_idle("ovf");

        // Wrap-around: 12 bytes, pushing only when not full.
        begin
            int k = 0;
            int guard = 0;
            while (k < 12 && guard < 2000) begin
                @(negedge clk);
                guard++;
                if (full === 1'b0) begin
                    wr_en = 1'b1; wr_data = 8'(k); exp_q.push_back(8'(k)); k++;
                end else begin
                    wr_en = 1'b0;
                end
            end
            @(negedge clk);
            wr_en = 1'b0;
            check("w_all_pushed", 32'(k), 32'd12);
        end
        wait_idle("wrap");
        check("w_empty", 32'(empty), 32'd1);
        check("w_ovf", 32'(overflow), 32'd0);

        // Reset during data bit 3.
        push(8'h5A, 1'b0);
        repeat (17) @(negedge clk);
        check("r_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("r_txd", 32'(txd), 32'd1);
        check("r_busy", 32'(busy), 32'd0);
        check("r_level", 32'(level), 32'd0);
        check("r_empty", 32'(empty), 32'd1);
        check("r_done", 32'(tx_done), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        push(8'hFF, 1'b1);
        wait_idle("post_reset");

`ifdef UART_TX_PARITY_EN
        // Parity: 0x07 has odd weight, parity bit 1, 44-clock frame.
        done_cyc.delete();
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h07; exp_q.push_back(8'h07);
        @(negedge clk);
        wr_en = 1'b0; c0 = cyc;
        wait_idle("parity");
        if (done_cyc.size() > 0) check("p_done_cycle", 32'(done_cyc[0] - c0), 32'd44);
`endif

        repeat (5) @(negedge clk);
        check("total_done", 32'(done_cnt), 32'(EXP_DONE));
        check("total_frames", 32'(frames), 32'(EXP_DONE));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
